mult_div_sequencer: RTL and testbench

MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

---
 rtl/mult_div_sequencer.sv | 146 ++++++++++++++
 tb/tb_mult_div_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// Iterative 32-bit multiply/divide sequencer for the HI/LO unit.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix at end.
module mult_div_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state_q, state_d;
   logic        is_div_q;
   logic        neg_res_q;
   logic        neg_rem_q;
   logic [5:0]  cnt_q;
   logic [31:0] opnd_q;
   logic [63:0] acc_q;
   logic [31:0] rem_q;

   logic        signed_op;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic        accept;
   logic        dz;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_sh;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [32:0] rem_next;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign signed_op = ~op[0];
   assign a_neg     = signed_op & a_in[31];
   assign b_neg     = signed_op & b_in[31];
   assign a_mag     = a_neg ? -a_in : a_in;
   assign b_mag     = b_neg ? -b_in : b_in;
   assign accept    = start & ~abort;
   assign dz        = op[1] & (b_in == 32'd0);

   // opnd_q holds the multiplicand or the divisor; acc_q[31:0] the other operand
   assign mul_sum  = {1'b0, acc_q[63:32]}
                   + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next = {mul_sum, acc_q[31:1]};

   assign div_sh   = {rem_q, acc_q[31]};
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_ge   = ~div_diff[32];
   assign rem_next = div_ge ? div_diff : div_sh;

   assign prod_fix = neg_res_q ? -acc_q : acc_q;
   assign quo_fix  = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
   assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = dz ? DONE : CALC;
         CALC: begin
            if (abort)               state_d = IDLE;
            else if (cnt_q == 6'd31) state_d = FIX;
         end
         FIX:  state_d = abort ? IDLE : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == CALC) || (state_q == FIX);
   assign done = (state_q == DONE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= 6'd0;
         opnd_q    <= 32'd0;
         acc_q     <= 64'd0;
         rem_q     <= 32'd0;
         div_zero  <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  div_zero  <= dz;
                  is_div_q  <= op[1];
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  cnt_q     <= 6'd0;
                  rem_q     <= 32'd0;
                  if (op[1]) begin
                     opnd_q <= b_mag;
                     acc_q  <= {32'd0, a_mag};
                  end else begin
                     opnd_q <= a_mag;
                     acc_q  <= {32'd0, b_mag};
                  end
               end
            end
            CALC: begin
               if (!abort) begin
                  cnt_q <= cnt_q + 6'd1;
                  if (is_div_q) begin
                     acc_q[31:0] <= {acc_q[30:0], div_ge};
                     rem_q       <= rem_next[31:0];
                  end else begin
                     acc_q <= mul_next;
                  end
               end
            end
            FIX: begin
               if (!abort) begin
                  if (is_div_q) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     hi <= prod_fix[63:32];
                     lo <= prod_fix[31:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer against an arithmetic model.
// Directed corner cases, abort and async reset, then randomized operations.
module tb_mult_div_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a_in = 32'd0;
   logic [31:0] b_in = 32'd0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic        m_dz = 1'b0;

   mult_div_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .a_in(a_in), .b_in(b_in), .abort(abort),
      .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      longint sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o[1] && b == 32'd0) begin
         m_dz = 1'b1;
         return;
      end
      m_dz = 1'b0;
      case (o)
         2'd0: begin
            p = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         2'd1: begin
            p = 64'(a) * 64'(b);
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         2'd2: begin
            sq = sa / sb;
            sr = sa % sb;
            m_lo = sq[31:0];
            m_hi = sr[31:0];
         end
         default: begin
            m_lo = a / b;
            m_hi = a % b;
         end
      endcase
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit noise);
      int bc;
      bit early;
      @(negedge clock);
      start = 1'b1; op = o; a_in = a; b_in = b;
      model(o, a, b);
      @(negedge clock);
      start = 1'b0;
      op = 2'($urandom); a_in = $urandom; b_in = $urandom;
      if (o[1] && b == 32'd0) begin
         chk("dz_done", 64'(done), 64'(1));
         chk("dz_busy", 64'(busy), 64'(0));
         chk("dz_flag", 64'(div_zero), 64'(1));
         chk("dz_hi", 64'(hi), 64'(m_hi));
         chk("dz_lo", 64'(lo), 64'(m_lo));
         @(negedge clock);
         chk("dz_done_pulse", 64'(done), 64'(0));
         return;
      end
      bc = 0;
      early = 1'b0;
      repeat (33) begin
         if (busy) bc++;
         if (done) early = 1'b1;
         if (noise) start = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      start = 1'b0;
      chk("busy_cycles", 64'(bc), 64'(33));
      chk("no_early_done", 64'(early), 64'(0));
      chk("done_at_e33", 64'(done), 64'(1));
      chk("busy_in_done", 64'(busy), 64'(0));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
      @(negedge clock);
      chk("done_pulse", 64'(done), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
   endtask

   task automatic abort_run(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int k);
      bit seen;
      @(negedge clock);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(negedge clock);
      start = 1'b0;
      m_dz = 1'b0;
      repeat (k) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      start = 1'b0;
      chk("abort_pre_busy", 64'(busy), 64'(1));
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort_idle", 64'(busy), 64'(0));
      seen = 1'b0;
      repeat (40) begin
         if (done || busy) seen = 1'b1;
         @(negedge clock);
      end
      chk("abort_no_done", 64'(seen), 64'(0));
      chk("abort_hi", 64'(hi), 64'(m_hi));
      chk("abort_lo", 64'(lo), 64'(m_lo));
      chk("abort_dz", 64'(div_zero), 64'(m_dz));
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      repeat (2) @(negedge clock);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_dz", 64'(div_zero), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      reset = 1'b1;

      run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      chk("multu_max_lo", 64'(lo), 64'h1);

      run(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
      chk("mult_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      chk("mult_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);

      run(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
      chk("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      chk("div_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);

      run(2'd3, 32'd100, 32'd0, 1'b0);
      run(2'd1, 32'd2, 32'd3, 1'b0);
      chk("after_dz_lo", 64'(lo), 64'd6);
      chk("after_dz_flag", 64'(div_zero), 64'd0);

      abort_run(2'd1, 32'd5, 32'd5, 9);

      @(negedge clock);
      start = 1'b1; abort = 1'b1; op = 2'd3; a_in = 32'd1; b_in = 32'd0;
      @(negedge clock);
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", 64'(busy), 64'(0));
      chk("idle_abort_done", 64'(done), 64'(0));
      chk("idle_abort_dz", 64'(div_zero), 64'(m_dz));

      run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
      chk("div_ovf_hi", 64'(hi), 64'd0);
      chk("div_ovf_dz", 64'(div_zero), 64'd0);

      repeat (24) begin
         ro = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run(ro, ra, rb, 1'b1);
      end

      @(negedge clock);
      start = 1'b1; op = 2'd2; a_in = 32'h1234_5678; b_in = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (19) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
      chk("async_busy", 64'(busy), 64'(0));
      chk("async_done", 64'(done), 64'(0));
      chk("async_dz", 64'(div_zero), 64'(0));
      chk("async_hi", 64'(hi), 64'(0));
      chk("async_lo", 64'(lo), 64'(0));
      @(negedge clock);
      reset = 1'b1;
      run(2'd3, 32'd9, 32'd4, 1'b0);
      chk("divu_9_4_lo", 64'(lo), 64'd2);
      chk("divu_9_4_hi", 64'(hi), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
